e203_extend_csr_arbt: RTL and testbench

//  Arbiter/sequencer in front of the extended-CSR (NICE CSR) port. Shares the single

---
 rtl/e203_extend_csr_arbt.sv | 178 +++++++++++++++++
 tb/tb_e203_extend_csr_arbt.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_extend_csr_arbt.sv
// e203_extend_csr_arbt: shares the single NICE CSR valid/ready port between two
// requesters (i0 = core EXU CSR path, i1 = debug/system path). One transaction is in
// flight at a time: IDLE (arbitrate) -> REQ (drive downstream) -> RSP (return rdata).
// Ties between simultaneous requesters are broken round-robin.
// Optional feature macro: E203_EXTEND_CSR_TIMEOUT_EN. When defined, a REQ that sees no
// nice_csr_ready for TMO_CYC cycles is aborted and answered with err=1, rdata=0.
module e203_extend_csr_arbt #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i0_csr_valid,
    output logic        i0_csr_ready,
    input  logic [31:0] i0_csr_addr,
    input  logic        i0_csr_wr,
    input  logic [31:0] i0_csr_wdata,
    output logic        i0_rsp_valid,
    input  logic        i0_rsp_ready,
    output logic [31:0] i0_rsp_rdata,
    output logic        i0_rsp_err,

    input  logic        i1_csr_valid,
    output logic        i1_csr_ready,
    input  logic [31:0] i1_csr_addr,
    input  logic        i1_csr_wr,
    input  logic [31:0] i1_csr_wdata,
    output logic        i1_rsp_valid,
    input  logic        i1_rsp_ready,
    output logic [31:0] i1_rsp_rdata,
    output logic        i1_rsp_err,

    output logic        nice_csr_valid,
    input  logic        nice_csr_ready,
    output logic [31:0] nice_csr_addr,
    output logic        nice_csr_wr,
    output logic [31:0] nice_csr_wdata,
    input  logic [31:0] nice_csr_rdata,

    output logic        arbt_busy
);

    // TMO_CYC must fit the counter: the abort compare uses TMO_CYC-1 as a TMO_W-bit value.
    if ((TMO_CYC < 1) || (TMO_CYC > (2 ** TMO_W) - 1)) begin : g_bad_tmo_param
        $error("e203_extend_csr_arbt: TMO_CYC out of range for TMO_W");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StRsp  = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;

    logic        r_rr_ptr;
    logic        r_id;
    logic [31:0] r_addr;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_idle;
    logic        w_in_req;
    logic        w_in_rsp;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic        w_done;
    logic        w_tmo;
    logic        w_rsp_hs;

    assign w_idle   = (r_state == StIdle);
    assign w_in_req = (r_state == StReq);
    assign w_in_rsp = (r_state == StRsp);

    // A lone requester always wins; on a tie rr_ptr picks (0 -> i0, 1 -> i1).
    assign w_gnt0   = i0_csr_valid & (~i1_csr_valid | ~r_rr_ptr);
    assign w_gnt1   = i1_csr_valid & (~i0_csr_valid |  r_rr_ptr);
    assign w_accept = w_idle & (w_gnt0 | w_gnt1);

    assign w_done   = w_in_req & nice_csr_ready;
    assign w_rsp_hs = w_in_rsp & (r_id ? i1_rsp_ready : i0_rsp_ready);

`ifdef E203_EXTEND_CSR_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;

    // Timeout counter: cleared on entry to REQ, counts REQ cycles without downstream accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (w_in_req && !nice_csr_ready) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Abort only when ready is still low; a ready in the same cycle completes normally.
    assign w_tmo = w_in_req & ~nice_csr_ready & (r_tmo_cnt == TMO_W'(TMO_CYC - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_accept)                 w_state_nxt = StReq;
            StReq:  if (nice_csr_ready || w_tmo)  w_state_nxt = StRsp;
            StRsp:  if (w_rsp_hs)                 w_state_nxt = StIdle;
            default:                              w_state_nxt = StIdle;
        endcase
    end

    // Capture the winning request on accept; held stable for the whole REQ phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= 1'b0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_id    <= w_gnt1;
            r_addr  <= w_gnt1 ? i1_csr_addr  : i0_csr_addr;
            r_wr    <= w_gnt1 ? i1_csr_wr    : i0_csr_wr;
            r_wdata <= w_gnt1 ? i1_csr_wdata : i0_csr_wdata;
        end
    end

    // Capture the response and hand priority to the other requester when REQ ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else if (w_done) begin
            r_rdata  <= nice_csr_rdata;
            r_err    <= 1'b0;
            r_rr_ptr <= ~r_id;
        end else if (w_tmo) begin
            r_rdata  <= '0;
            r_err    <= 1'b1;
            r_rr_ptr <= ~r_id;
        end
    end

    // Ready is combinational; gating with rst_n keeps it low while reset is held.
    assign i0_csr_ready   = rst_n & w_idle & w_gnt0;
    assign i1_csr_ready   = rst_n & w_idle & w_gnt1;

    assign nice_csr_valid = w_in_req;
    assign nice_csr_addr  = r_addr;
    assign nice_csr_wr    = r_wr;
    assign nice_csr_wdata = r_wdata;

    assign i0_rsp_valid   = w_in_rsp & ~r_id;
    assign i1_rsp_valid   = w_in_rsp &  r_id;
    assign i0_rsp_rdata   = r_rdata;
    assign i1_rsp_rdata   = r_rdata;
    assign i0_rsp_err     = r_err;
    assign i1_rsp_err     = r_err;

    assign arbt_busy      = ~w_idle;

endmodule

// File: tb/tb_e203_extend_csr_arbt.sv
// Bench for e203_extend_csr_arbt: directed round-robin/reset/timeout scenarios plus
// randomized traffic, checked by a transaction-level scoreboard running on negedges.
module tb_e203_extend_csr_arbt;

    localparam int unsigned TMO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i0_csr_valid, i0_csr_ready, i0_csr_wr, i0_rsp_valid, i0_rsp_ready, i0_rsp_err;
    logic        i1_csr_valid, i1_csr_ready, i1_csr_wr, i1_rsp_valid, i1_rsp_ready, i1_rsp_err;
    logic [31:0] i0_csr_addr, i0_csr_wdata, i0_rsp_rdata;
    logic [31:0] i1_csr_addr, i1_csr_wdata, i1_rsp_rdata;
    logic        nice_csr_valid, nice_csr_ready, nice_csr_wr, arbt_busy;
    logic [31:0] nice_csr_addr, nice_csr_wdata, nice_csr_rdata;

    always #5 clk = ~clk;

    e203_extend_csr_arbt #(
        .TMO_W   (8),
        .TMO_CYC (TMO_CYC)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i0_csr_valid   (i0_csr_valid),
        .i0_csr_ready   (i0_csr_ready),
        .i0_csr_addr    (i0_csr_addr),
        .i0_csr_wr      (i0_csr_wr),
        .i0_csr_wdata   (i0_csr_wdata),
        .i0_rsp_valid   (i0_rsp_valid),
        .i0_rsp_ready   (i0_rsp_ready),
        .i0_rsp_rdata   (i0_rsp_rdata),
        .i0_rsp_err     (i0_rsp_err),
        .i1_csr_valid   (i1_csr_valid),
        .i1_csr_ready   (i1_csr_ready),
        .i1_csr_addr    (i1_csr_addr),
        .i1_csr_wr      (i1_csr_wr),
        .i1_csr_wdata   (i1_csr_wdata),
        .i1_rsp_valid   (i1_rsp_valid),
        .i1_rsp_ready   (i1_rsp_ready),
        .i1_rsp_rdata   (i1_rsp_rdata),
        .i1_rsp_err     (i1_rsp_err),
        .nice_csr_valid (nice_csr_valid),
        .nice_csr_ready (nice_csr_ready),
        .nice_csr_addr  (nice_csr_addr),
        .nice_csr_wr    (nice_csr_wr),
        .nice_csr_wdata (nice_csr_wdata),
        .nice_csr_rdata (nice_csr_rdata),
        .arbt_busy      (arbt_busy)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   gq[$];

    int   checks = 0;
    int   errors = 0;
    int   n_rsp  = 0;

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check_zero(input string nm);
        chk1({nm, "_i0_ready"}, i0_csr_ready, 1'b0);
        chk1({nm, "_i1_ready"}, i1_csr_ready, 1'b0);
        chk1({nm, "_i0_rspv"}, i0_rsp_valid, 1'b0);
        chk1({nm, "_i1_rspv"}, i1_rsp_valid, 1'b0);
        chk1({nm, "_err"}, i0_rsp_err | i1_rsp_err, 1'b0);
        chk1({nm, "_dn_valid"}, nice_csr_valid, 1'b0);
        chk1({nm, "_dn_wr"}, nice_csr_wr, 1'b0);
        chk1({nm, "_busy"}, arbt_busy, 1'b0);
        chk32({nm, "_dn_addr"}, nice_csr_addr, 32'h0);
        chk32({nm, "_dn_wdata"}, nice_csr_wdata, 32'h0);
        chk32({nm, "_rdata"}, i0_rsp_rdata | i1_rsp_rdata, 32'h0);
    endtask

    task automatic new_req(input int n);
        if (n == 0) begin
            i0_csr_valid = 1'b1;
            i0_csr_addr  = $urandom() & 32'hFFF;
            i0_csr_wr    = (($urandom() & 1) != 0);
            i0_csr_wdata = $urandom();
        end else begin
            i1_csr_valid = 1'b1;
            i1_csr_addr  = $urandom() & 32'hFFF;
            i1_csr_wr    = (($urandom() & 1) != 0);
            i1_csr_wdata = $urandom();
        end
    endtask

    // Scoreboard: one transaction in flight; phase 0 arbitrate, 1 downstream, 2 response.
    initial begin : monitor
        int   phase;
        int   stall;
        logic rr;
        logic w0, w1;
        req_t q;
        rsp_t r;
        phase = 0;
        stall = 0;
        rr    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0;
                stall = 0;
                rr    = 1'b0;
                exp_req.delete();
                exp_rsp.delete();
            end else if (phase == 0) begin
                w0 = i0_csr_valid && (!i1_csr_valid || !rr);
                w1 = i1_csr_valid && !w0;
                chk1("grant0", i0_csr_ready, w0);
                chk1("grant1", i1_csr_ready, w1);
                chk1("idle_dn_valid", nice_csr_valid, 1'b0);
                chk1("idle_busy", arbt_busy, 1'b0);
                chk1("idle_rsp_valid", i0_rsp_valid | i1_rsp_valid, 1'b0);
                if (w0 || w1) begin
                    q.id    = w1;
                    q.addr  = w1 ? i1_csr_addr  : i0_csr_addr;
                    q.wr    = w1 ? i1_csr_wr    : i0_csr_wr;
                    q.wdata = w1 ? i1_csr_wdata : i0_csr_wdata;
                    exp_req.push_back(q);
                    phase = 1;
                    stall = 0;
                end
            end else if (phase == 1) begin
                q = exp_req[0];
                chk1("req_valid", nice_csr_valid, 1'b1);
                chk32("req_addr", nice_csr_addr, q.addr);
                chk1("req_wr", nice_csr_wr, q.wr);
                chk32("req_wdata", nice_csr_wdata, q.wdata);
                chk1("req_busy", arbt_busy, 1'b1);
                chk1("req_no_grant", i0_csr_ready | i1_csr_ready, 1'b0);
                chk1("req_no_rsp", i0_rsp_valid | i1_rsp_valid, 1'b0);
                if (nice_csr_ready) begin
                    r.id    = q.id;
                    r.rdata = nice_csr_rdata;
                    r.err   = 1'b0;
                    exp_rsp.push_back(r);
                    void'(exp_req.pop_front());
                    rr    = ~q.id;
                    phase = 2;
                end
`ifdef E203_EXTEND_CSR_TIMEOUT_EN
                else begin
                    stall++;
                    if (stall == TMO_CYC) begin
                        r.id    = q.id;
                        r.rdata = 32'h0;
                        r.err   = 1'b1;
                        exp_rsp.push_back(r);
                        void'(exp_req.pop_front());
                        rr    = ~q.id;
                        phase = 2;
                    end
                end
`endif
            end else begin
                r = exp_rsp[0];
                chk1("rsp_valid0", i0_rsp_valid, ~r.id);
                chk1("rsp_valid1", i1_rsp_valid, r.id);
                chk32("rsp_rdata", r.id ? i1_rsp_rdata : i0_rsp_rdata, r.rdata);
                chk1("rsp_err", r.id ? i1_rsp_err : i0_rsp_err, r.err);
                chk1("rsp_dn_valid", nice_csr_valid, 1'b0);
                chk1("rsp_no_grant", i0_csr_ready | i1_csr_ready, 1'b0);
                if (r.id ? i1_rsp_ready : i0_rsp_ready) begin
                    void'(exp_rsp.pop_front());
                    n_rsp++;
                    phase = 0;
                end
            end
        end
    end

    logic a0, a1;
    int   lowcnt;
    int   w;
    int   cnt_v;

    initial begin : stim
        rst_n          = 1'b0;
        i0_csr_valid   = 1'b0; i0_csr_addr = '0; i0_csr_wr = 1'b0; i0_csr_wdata = '0;
        i1_csr_valid   = 1'b0; i1_csr_addr = '0; i1_csr_wr = 1'b0; i1_csr_wdata = '0;
        i0_rsp_ready   = 1'b0;
        i1_rsp_ready   = 1'b0;
        nice_csr_ready = 1'b0;
        nice_csr_rdata = '0;
        lowcnt         = 0;
        #3;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Both requesters valid continuously, everything else immediately ready.
        @(posedge clk); #1;
        i0_csr_valid = 1'b1; i0_csr_addr = 32'h7C0; i0_csr_wr = 1'b0; i0_csr_wdata = 32'h0;
        i1_csr_valid = 1'b1; i1_csr_addr = 32'h7C1; i1_csr_wr = 1'b1; i1_csr_wdata = 32'hDEADBEEF;
        nice_csr_ready = 1'b1;
        i0_rsp_ready   = 1'b1;
        i1_rsp_ready   = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (i0_csr_ready) gq.push_back(0);
            if (i1_csr_ready) gq.push_back(1);
            if (nice_csr_valid && nice_csr_wr) chk32("i1_wdata", nice_csr_wdata, 32'hDEADBEEF);
            @(posedge clk); #1;
            nice_csr_rdata = $urandom();
        end
        chk1("grant_count", gq.size() >= 4, 1'b1);
        for (int k = 0; k < 4 && k < gq.size(); k++) begin
            chk32("grant_order", gq[k], k % 2);
        end

        // Randomized traffic with a reset dropped into the middle of a REQ phase.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a0 = i0_csr_valid & i0_csr_ready;
            a1 = i1_csr_valid & i1_csr_ready;
            if (c == 1500) begin
                @(posedge clk); #1;
                new_req(0);
                nice_csr_ready = 1'b0;
                i0_rsp_ready   = 1'b1;
                i1_rsp_ready   = 1'b1;
                w = 0;
                while (!nice_csr_valid && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                chk1("rst_reach_req", nice_csr_valid, 1'b1);
                #2 rst_n = 1'b0;
                #1 check_zero("rst_mid");
                i0_csr_valid   = 1'b0;
                i1_csr_valid   = 1'b0;
                nice_csr_ready = 1'b1;
                lowcnt         = 0;
                @(posedge clk);
                @(posedge clk);
                #2 rst_n = 1'b1;
                new_req(1);
            end else begin
                @(posedge clk); #1;
                if (i0_csr_valid) begin
                    if (a0) begin
                        if ($urandom_range(2, 0) != 0) new_req(0);
                        else i0_csr_valid = 1'b0;
                    end else if ($urandom_range(15, 0) == 0) begin
                        i0_csr_valid = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    new_req(0);
                end
                if (i1_csr_valid) begin
                    if (a1) begin
                        if ($urandom_range(2, 0) != 0) new_req(1);
                        else i1_csr_valid = 1'b0;
                    end else if ($urandom_range(15, 0) == 0) begin
                        i1_csr_valid = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    new_req(1);
                end
                // Downstream stalls are bounded well below the abort threshold.
                nice_csr_ready = (lowcnt >= 6) || ($urandom_range(2, 0) != 0);
                lowcnt         = nice_csr_ready ? 0 : lowcnt + 1;
                nice_csr_rdata = $urandom();
                i0_rsp_ready   = ($urandom_range(3, 0) != 0);
                i1_rsp_ready   = ($urandom_range(3, 0) != 0);
            end
        end

        // Drain, then hold downstream ready low for a long single request.
        @(posedge clk); #1;
        i0_csr_valid   = 1'b0;
        i1_csr_valid   = 1'b0;
        nice_csr_ready = 1'b1;
        i0_rsp_ready   = 1'b1;
        i1_rsp_ready   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        nice_csr_ready = 1'b0;
        i0_csr_valid   = 1'b1;
        i0_csr_addr    = 32'h7C0;
        i0_csr_wr      = 1'b0;
        i0_csr_wdata   = 32'h0;
        w = 0;
        @(negedge clk);
        while (!i0_csr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk1("tmo_accept", i0_csr_ready, 1'b1);
        @(posedge clk); #1;
        i0_csr_valid = 1'b0;
        cnt_v = 0;
        repeat (40) begin
            @(negedge clk);
            if (nice_csr_valid) cnt_v++;
        end
`ifdef E203_EXTEND_CSR_TIMEOUT_EN
        chk32("tmo_valid_cycles", cnt_v, TMO_CYC);
`else
        chk32("tmo_valid_cycles", cnt_v, 40);
`endif
        @(posedge clk); #1;
        nice_csr_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk1("final_idle", arbt_busy, 1'b0);
        chk1("progress", n_rsp >= 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
